cusp_event_ctrl: RTL and testbench
==================================

Name: cusp_event_ctrl

Overview:
- Event scheduler placed directly after the cusp-like shaping filter.
- Gates the filter output after reset until the pipeline has settled, then detects rising threshold crossings.
- For each crossing it captures the peak amplitude over a fixed window, timestamps the event, flags pile-up, and enforces dead time.
- Events are presented to the readout on a valid/ready handshake, and crossings that cannot be served are counted as dropped.

Parameters:
DATA_W, SIZE_FILTER_DATA+1 (from package_settings), width of the signed filter sample.
TS_W, 32, width of the free-running timestamp counter.
PEAK_WIN, 16, peak-search window in samples, crossing sample included; range 2..255.
DEAD_TIME, 32, dead-time cycles after each accepted event; 0 is allowed.
SETTLE_CYC, 24, cycles after reset during which filter output is ignored; must be ≥ the filter pipeline depth.
DROP_W, 16, width of the dropped-crossing counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  trigger enable; level-sensitive
threshold  in  DATA_W  signed trigger threshold; sampled every cycle
filt_data  in  DATA_W  signed filter output, one sample per clk
event_valid  out  1  event record available
event_ready  in  1  consumer accepts the record
event_amp  out  DATA_W  signed peak value found in the window
event_time  out  TS_W  timestamp of the crossing sample
event_pileup  out  1  a second crossing occurred inside the window
busy  out  1  high in every state except IDLE
dropped_cnt  out  DROP_W  saturating count of crossings that were not served

Behaviour:
- Reset (asynchronous, active-low): state=SETTLE; all outputs 0; timestamp=0; previous-sample register=0.
- Timestamp: increments every cycle from reset and wraps modulo 2^TS_W.
- Crossing: asserted on a clock edge when filt_data > threshold (signed compare) and the previous registered sample ≤ threshold. The previous sample updates every cycle in every state, SETTLE included.
- SETTLE:
  - Counts SETTLE_CYC cycles, then moves to IDLE.
  - Crossings seen in SETTLE are ignored and not counted.
- IDLE:
  - On a crossing with enable=1: move to SEARCH, peak<=filt_data, time<=timestamp, cnt<=1, pileup<=0.
  - With enable=0, crossings are ignored and not counted.
- SEARCH, on each edge:
  - peak<=max(peak, filt_data).
  - A new crossing (the signal fell to ≤ threshold and rose again) sets pileup.
  - When cnt==PEAK_WIN-1: event_amp<=max(peak, filt_data), event_time and event_pileup are loaded, event_valid<=1, state moves to REPORT. Otherwise cnt++.
  - Resulting latency: event_valid rises PEAK_WIN-1 cycles after the crossing edge.
  - enable falling in SEARCH aborts to IDLE with no event and no drop count.
- REPORT:
  - event_valid and the record fields are held stable until event_valid & event_ready at an edge.
  - On that edge: event_valid<=0. If DEAD_TIME=0, go to IDLE; otherwise load the dead counter and go to DEAD.
  - enable has no effect in REPORT.
- DEAD: counts DEAD_TIME cycles, then goes to IDLE.
- Drops:
  - A crossing in REPORT or DEAD increments dropped_cnt, saturating at all-ones.
  - A crossing on the same edge that IDLE is re-entered is not served and counts as a drop.
- Simultaneous events: a crossing on the exit edge from DEAD counts as a drop; the next crossing from IDLE is served normally.
- Equality: filt_data == threshold is not a crossing.
- Reset mid-operation: any pending event is discarded and the block returns to SETTLE.
- Width rules: all compares are signed over DATA_W bits; no arithmetic is performed on samples.

Decomposition:
- package_settings: supplies SIZE_FILTER_DATA.
- New package cusp_event_pkg holds:
  - state enum (SETTLE, IDLE, SEARCH, REPORT, DEAD);
  - event record struct (amp, time, pileup);
  - default window and dead-time constants.
- One natural sub-module, cusp_xing_det: registers the previous sample and produces the crossing strobe. It is shared by the IDLE and SEARCH logic and by the drop counter.

Test Plan:
1. Settle gate:
   - Stimulus: reset, then filt_data=500 on cycle 5 (SETTLE_CYC=24).
   - Required: no event, dropped_cnt=0. A crossing to 150 on cycle 30 with threshold=100 yields an event.
2. Basic event:
   - Stimulus: PEAK_WIN=4, threshold=100, samples 0,150,300,200,120, event_ready=1, crossing at timestamp T.
   - Required: event_valid rises 3 cycles after the crossing edge, amp=300, time=T, pileup=0, single-cycle valid.
3. Backpressure and drop:
   - Stimulus: hold event_ready=0 for 10 cycles while two more crossings occur.
   - Required: record stable throughout, dropped_cnt=2. Ready=1 completes the transfer, then DEAD lasts 32 cycles.
4. Pile-up:
   - Stimulus: PEAK_WIN=6, samples 150,90,250,…
   - Required: pileup=1, amp=250.
5. Edge cases:
   - threshold=100 with sample exactly 100 → no crossing.
   - enable dropped in SEARCH → returns to IDLE, no event, no drop.
   - DEAD_TIME=0 → IDLE on the cycle after the handshake.
6. Reset during REPORT:
   - Stimulus: assert reset while event_valid=1.
   - Required: event_valid=0 immediately (asynchronous), dropped_cnt=0, timestamp=0, state=SETTLE.

Source files
------------

// File: rtl/cusp_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cusp_event_pkg
// Description : Types and default constants for the cusp event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package cusp_event_pkg;

    localparam int c_data_w         = package_settings::SIZE_FILTER_DATA + 1;
    localparam int c_ts_w           = 32;
    localparam int c_peak_win_def   = 16;
    localparam int c_dead_time_def  = 32;
    localparam int c_settle_cyc_def = 24;
    localparam int c_drop_w_def     = 16;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_REPORT = 3'd3,
        ST_DEAD   = 3'd4
    } cusp_state_t;

    // Record handed to the readout; sized by the package-level sample width.
    typedef struct packed {
        logic signed [c_data_w-1:0] amp;
        logic        [c_ts_w-1:0]   tstamp;
        logic                       pileup;
    } cusp_event_t;

endpackage
`default_nettype wire

// File: rtl/package_settings.sv
`default_nettype none
// ============================================================================
// Module      : package_settings
// Description : Global front-end settings shared by the filter and the
//               blocks that consume its output.
// Revision    : 1.0 - initial release
// ============================================================================
package package_settings;

    // Magnitude bits of the shaping-filter output; one sign bit is added on top.
    localparam int SIZE_FILTER_DATA = 15;

endpackage
`default_nettype wire

// File: rtl/cusp_xing_det.sv
`default_nettype none
// ============================================================================
// Module      : cusp_xing_det
// Description : Rising threshold-crossing detector. Keeps the previous sample
//               and flags the cycle where the signal goes from <= threshold
//               to > threshold (signed compare, equality is not a crossing).
// Revision    : 1.0 - initial release
// ============================================================================
module cusp_xing_det #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filt_data,
    input  logic signed [DATA_W-1:0] threshold,
    output logic                     xing
);

    logic signed [DATA_W-1:0] r_prev;

    // Previous sample tracks the filter every cycle regardless of controller state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= filt_data;
        end
    end

    assign xing = (filt_data > threshold) && (r_prev <= threshold);

endmodule
`default_nettype wire

// File: rtl/cusp_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cusp_event_ctrl
// Description : Event scheduler after the cusp shaping filter. Waits for the
//               filter to settle, then on each rising crossing captures the
//               window peak and timestamp, flags pile-up, hands the record
//               out on valid/ready and enforces dead time. Crossings that
//               cannot be served are counted (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module cusp_event_ctrl
    import cusp_event_pkg::*;
#(
    parameter int DATA_W     = package_settings::SIZE_FILTER_DATA + 1,
    parameter int TS_W       = c_ts_w,
    parameter int PEAK_WIN   = c_peak_win_def,
    parameter int DEAD_TIME  = c_dead_time_def,
    parameter int SETTLE_CYC = c_settle_cyc_def,
    parameter int DROP_W     = c_drop_w_def
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] filt_data,
    output logic                     event_valid,
    input  logic                     event_ready,
    output logic signed [DATA_W-1:0] event_amp,
    output logic [TS_W-1:0]          event_time,
    output logic                     event_pileup,
    output logic                     busy,
    output logic [DROP_W-1:0]        dropped_cnt
);

    cusp_state_t              r_state;
    cusp_state_t              w_state_next;
    logic                     w_xing;
    logic                     w_start;
    logic                     w_finish;
    logic                     w_hs;
    logic                     w_drop_evt;
    logic signed [DATA_W-1:0] w_peak_max;

    logic [TS_W-1:0]          r_ts;
    logic [31:0]              r_settle_cnt;
    logic [7:0]               r_win_cnt;
    logic [31:0]              r_dead_cnt;
    logic signed [DATA_W-1:0] r_peak;
    logic [TS_W-1:0]          r_time;
    logic                     r_pileup;
    cusp_event_t              r_rec;
    logic                     r_valid;
    logic                     r_busy;
    logic [DROP_W-1:0]        r_drop;

    cusp_xing_det #(
        .DATA_W    (DATA_W)
    ) u_xing_det (
        .clk       (clk),
        .reset     (reset),
        .filt_data (filt_data),
        .threshold (threshold),
        .xing      (w_xing)
    );

    assign w_peak_max = (filt_data > r_peak) ? filt_data : r_peak;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the per-edge control strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        w_hs         = 1'b0;
        w_drop_evt   = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (r_settle_cnt == 32'(SETTLE_CYC - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_xing && enable) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Losing enable mid-window discards the event silently.
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_win_cnt == 8'(PEAK_WIN - 1)) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_drop_evt = w_xing;
                if (r_valid && event_ready) begin
                    w_hs         = 1'b1;
                    w_state_next = (DEAD_TIME == 0) ? ST_IDLE : ST_DEAD;
                end
            end
            ST_DEAD: begin
                w_drop_evt = w_xing;
                if (r_dead_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_SETTLE;
            end
        endcase
    end

    // Free-running timestamp and the settle / dead-time counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts         <= '0;
            r_settle_cnt <= '0;
            r_dead_cnt   <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            if (w_hs) begin
                r_dead_cnt <= 32'(DEAD_TIME - 1);
            end else if ((r_state == ST_DEAD) && (r_dead_cnt != '0)) begin
                r_dead_cnt <= r_dead_cnt - 1'b1;
            end
        end
    end

    // Peak search window: running max, crossing time, and pile-up flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak    <= '0;
            r_time    <= '0;
            r_win_cnt <= '0;
            r_pileup  <= 1'b0;
        end else if (w_start) begin
            r_peak    <= filt_data;
            r_time    <= r_ts;
            r_win_cnt <= 8'd1;
            r_pileup  <= 1'b0;
        end else if (r_state == ST_SEARCH) begin
            r_peak    <= w_peak_max;
            r_win_cnt <= r_win_cnt + 1'b1;
            if (w_xing) begin
                r_pileup <= 1'b1;
            end
        end
    end

    // Output record: loaded at window end, held until the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rec   <= '0;
            r_valid <= 1'b0;
        end else if (w_finish) begin
            r_rec.amp    <= w_peak_max;
            r_rec.tstamp <= r_time;
            r_rec.pileup <= r_pileup | w_xing;
            r_valid      <= 1'b1;
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating drop counter and registered busy (low during reset).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_drop_evt && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    assign event_valid  = r_valid;
    assign event_amp    = r_rec.amp;
    assign event_time   = r_rec.tstamp;
    assign event_pileup = r_rec.pileup;
    assign busy         = r_busy;
    assign dropped_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cusp_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cusp_event_ctrl
// Description : Self-checking bench for cusp_event_ctrl. Two instances
//               (short window with dead time, longer window without dead
//               time) share the stimulus and are compared against a
//               window/queue style reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cusp_event_ctrl;

    localparam int DW     = 16;
    localparam int TW     = 32;
    localparam int RW     = 16;
    localparam int SETTLE = 24;
    localparam int PW0    = 4;
    localparam int DT0    = 32;
    localparam int PW1    = 6;
    localparam int DT1    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 enable;
    logic                 event_ready;
    logic signed [DW-1:0] threshold;
    logic signed [DW-1:0] filt_data;

    logic                 v0, p0, b0, v1, p1, b1;
    logic signed [DW-1:0] a0, a1;
    logic [TW-1:0]        t0, t1;
    logic [RW-1:0]        d0, d1;

    cusp_event_ctrl #(.DATA_W(DW), .TS_W(TW), .PEAK_WIN(PW0), .DEAD_TIME(DT0),
                      .SETTLE_CYC(SETTLE), .DROP_W(RW)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .filt_data(filt_data), .event_valid(v0), .event_ready(event_ready),
        .event_amp(a0), .event_time(t0), .event_pileup(p0), .busy(b0),
        .dropped_cnt(d0));

    cusp_event_ctrl #(.DATA_W(DW), .TS_W(TW), .PEAK_WIN(PW1), .DEAD_TIME(DT1),
                      .SETTLE_CYC(SETTLE), .DROP_W(RW)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .filt_data(filt_data), .event_valid(v1), .event_ready(event_ready),
        .event_amp(a1), .event_time(t1), .event_pileup(p1), .busy(b1),
        .dropped_cnt(d1));

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int edges   = 0;
    int t_cross = 0;
    int pat[10] = '{0, 150, 0, 0, 150, 0, 0, 0, 0, 0};

    // Reference model: per instance, the open window as a list of samples,
    // a pending record, remaining settle / dead cycles, and the drop count.
    bit        m_rst;
    int        m_settle [2];
    int        m_n      [2];
    int        m_win    [2][256];
    bit [31:0] m_wtime  [2];
    bit        m_pile   [2];
    bit        m_pend   [2];
    int        m_amp    [2];
    bit [31:0] m_time   [2];
    bit        m_rp     [2];
    int        m_dead   [2];
    int        m_drop   [2];
    int        m_prev   [2];
    bit [31:0] m_ts     [2];

    function automatic int pw(input int k);
        return (k == 0) ? PW0 : PW1;
    endfunction

    function automatic int dt(input int k);
        return (k == 0) ? DT0 : DT1;
    endfunction

    function automatic logic [15:0] u16(input int v);
        return v[15:0];
    endfunction

    function automatic bit m_busy(input int k);
        return !m_rst && ((m_settle[k] > 0) || m_pend[k] || (m_dead[k] > 0) || (m_n[k] > 0));
    endfunction

    task automatic model_reset();
        m_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_settle[k] = SETTLE;
            m_n[k]      = 0;
            m_pile[k]   = 1'b0;
            m_pend[k]   = 1'b0;
            m_dead[k]   = 0;
            m_drop[k]   = 0;
            m_prev[k]   = 0;
            m_ts[k]     = '0;
        end
    endtask

    task automatic model_step(input int k);
        int fd;
        int th;
        int mx;
        bit x;
        fd = int'(filt_data);
        th = int'(threshold);
        x  = (fd > th) && (m_prev[k] <= th);
        if (m_settle[k] > 0) begin
            m_settle[k]--;
        end else if (m_pend[k]) begin
            if (x && m_drop[k] < 65535) m_drop[k]++;
            if (event_ready) begin
                m_pend[k] = 1'b0;
                m_dead[k] = dt(k);
            end
        end else if (m_dead[k] > 0) begin
            if (x && m_drop[k] < 65535) m_drop[k]++;
            m_dead[k]--;
        end else if (m_n[k] > 0) begin
            if (!enable) begin
                m_n[k] = 0;
            end else begin
                m_win[k][m_n[k]] = fd;
                m_n[k]++;
                if (x) m_pile[k] = 1'b1;
                if (m_n[k] == pw(k)) begin
                    mx = m_win[k][0];
                    for (int i = 1; i < m_n[k]; i++) if (m_win[k][i] > mx) mx = m_win[k][i];
                    m_amp[k]  = mx;
                    m_time[k] = m_wtime[k];
                    m_rp[k]   = m_pile[k];
                    m_pend[k] = 1'b1;
                    m_n[k]    = 0;
                end
            end
        end else if (x && enable) begin
            m_win[k][0] = fd;
            m_n[k]      = 1;
            m_wtime[k]  = m_ts[k];
            m_pile[k]   = 1'b0;
        end
        m_prev[k] = fd;
        m_ts[k]   = m_ts[k] + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid0", 64'(v0), 64'(m_pend[0]));
        chk("busy0",  64'(b0), 64'(m_busy(0)));
        chk("drop0",  64'(d0), 64'(m_drop[0]));
        chk("valid1", 64'(v1), 64'(m_pend[1]));
        chk("busy1",  64'(b1), 64'(m_busy(1)));
        chk("drop1",  64'(d1), 64'(m_drop[1]));
        if (m_pend[0]) begin
            chk("amp0",  64'(u16(a0)), 64'(u16(m_amp[0])));
            chk("time0", 64'(t0), 64'(m_time[0]));
            chk("pile0", 64'(p0), 64'(m_rp[0]));
        end
        if (m_pend[1]) begin
            chk("amp1",  64'(u16(a1)), 64'(u16(m_amp[1])));
            chk("time1", 64'(t1), 64'(m_time[1]));
            chk("pile1", 64'(p1), 64'(m_rp[1]));
        end
    endtask

    // One clock: drive inputs, advance the model, clock, then check #1 later.
    task automatic step(input int fd, input int th, input bit en, input bit rdy);
        filt_data   = DW'(fd);
        threshold   = DW'(th);
        enable      = en;
        event_ready = rdy;
        if (reset) begin
            model_step(0);
            model_step(1);
            edges++;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; event_ready = 1'b1;
        threshold = DW'(100); filt_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_busy",  64'(b0), 64'd0);
        chk("rst_drop",  64'(d0), 64'd0);
        chk("rst_amp",   64'(u16(a0)), 64'd0);
        chk("rst_time",  64'(t0), 64'd0);
        chk("rst_pile",  64'(p0), 64'd0);
        reset = 1'b1; m_rst = 1'b0; edges = 0;

        // Settle gate: early big sample ignored, later crossing served.
        for (int i = 1; i <= 29; i++) step((i == 5) ? 500 : 0, 100, 1'b1, 1'b1);
        chk("t1_valid", 64'(v0), 64'd0);
        chk("t1_drop",  64'(d0), 64'd0);
        chk("t1_busy",  64'(b0), 64'd0);
        step(150, 100, 1'b1, 1'b1);
        repeat (3) step(0, 100, 1'b1, 1'b1);
        chk("t1_ev_valid", 64'(v0), 64'd1);
        chk("t1_ev_time",  64'(t0), 64'd29);
        chk("t1_ev_amp",   64'(u16(a0)), 64'd150);
        repeat (50) step(0, 100, 1'b1, 1'b1);

        // Basic event.
        step(0, 100, 1'b1, 1'b1);
        t_cross = edges;
        step(150, 100, 1'b1, 1'b1);
        step(300, 100, 1'b1, 1'b1);
        step(200, 100, 1'b1, 1'b1);
        chk("t2_early", 64'(v0), 64'd0);
        step(120, 100, 1'b1, 1'b1);
        chk("t2_valid", 64'(v0), 64'd1);
        chk("t2_amp",   64'(u16(a0)), 64'd300);
        chk("t2_time",  64'(t0), 64'(t_cross));
        chk("t2_pile",  64'(p0), 64'd0);
        step(0, 100, 1'b1, 1'b1);
        chk("t2_single", 64'(v0), 64'd0);
        repeat (50) step(0, 100, 1'b1, 1'b1);

        // Backpressure with two dropped crossings, then dead time.
        step(150, 100, 1'b1, 1'b0);
        repeat (3) step(0, 100, 1'b1, 1'b0);
        chk("t3_valid", 64'(v0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step(pat[i], 100, 1'b1, 1'b0);
            chk("t3_hold_amp", 64'(u16(a0)), 64'd150);
        end
        chk("t3_drop", 64'(d0), 64'd2);
        step(0, 100, 1'b1, 1'b1);
        chk("t3_hs_valid", 64'(v0), 64'd0);
        chk("t3_hs_busy",  64'(b0), 64'd1);
        repeat (31) step(0, 100, 1'b1, 1'b1);
        chk("t3_dead_on",  64'(b0), 64'd1);
        step(0, 100, 1'b1, 1'b1);
        chk("t3_dead_off", 64'(b0), 64'd0);
        repeat (20) step(0, 100, 1'b1, 1'b1);

        // Pile-up.
        step(150, 100, 1'b1, 1'b1);
        step(90, 100, 1'b1, 1'b1);
        step(250, 100, 1'b1, 1'b1);
        step(0, 100, 1'b1, 1'b1);
        chk("t4_valid", 64'(v0), 64'd1);
        chk("t4_pile",  64'(p0), 64'd1);
        chk("t4_amp",   64'(u16(a0)), 64'd250);
        repeat (50) step(0, 100, 1'b1, 1'b1);

        // Equality is not a crossing; enable loss aborts the window.
        step(100, 100, 1'b1, 1'b1);
        chk("t5_eq_busy", 64'(b0), 64'd0);
        repeat (3) step(0, 100, 1'b1, 1'b1);
        step(150, 100, 1'b1, 1'b1);
        chk("t5_search", 64'(b0), 64'd1);
        step(200, 100, 1'b0, 1'b1);
        chk("t5_abort", 64'(b0), 64'd0);
        repeat (10) step(0, 100, 1'b1, 1'b1);
        chk("t5_noevent", 64'(v0), 64'd0);
        chk("t5_nodrop",  64'(d0), 64'd2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int th;
            int fd;
            th = ($urandom_range(9) == 0) ? int'($urandom_range(300)) - 50 : 100;
            fd = ($urandom_range(9) < 2) ? th : int'($urandom_range(600)) - 200;
            step(fd, th, $urandom_range(19) != 0, $urandom_range(3) != 0);
        end
        repeat (60) step(0, 100, 1'b1, 1'b1);

        // Asynchronous reset while a record is pending.
        step(0, 100, 1'b1, 1'b0);
        step(150, 100, 1'b1, 1'b0);
        repeat (3) step(0, 100, 1'b1, 1'b0);
        chk("t6_pending", 64'(v0), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid0", 64'(v0), 64'd0);
        chk("t6_valid1", 64'(v1), 64'd0);
        chk("t6_busy",   64'(b0), 64'd0);
        chk("t6_drop",   64'(d0), 64'd0);
        model_reset();
        @(negedge clk);
        step(0, 100, 1'b1, 1'b1);
        reset = 1'b1; m_rst = 1'b0; edges = 0;
        repeat (29) step(0, 100, 1'b1, 1'b1);
        step(150, 100, 1'b1, 1'b1);
        repeat (3) step(0, 100, 1'b1, 1'b1);
        chk("t6_ev_valid", 64'(v0), 64'd1);
        chk("t6_ev_time",  64'(t0), 64'd29);
        repeat (10) step(0, 100, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
